// File: rtl/l1_fill_ctrl_pkg.sv
// Shared types for the L1 block cache and its fill controller.
// CHUNK_WIDTH sets the coordinate width of BlockPos (signed, log2 of the chunk width).
`ifndef CHUNK_WIDTH
`define CHUNK_WIDTH 16
`endif

package l1_fill_ctrl_pkg;

    localparam int COORD_W = $clog2(`CHUNK_WIDTH);

    typedef logic signed [COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
        coord_t z;
    } BlockPos;

    typedef logic [7:0] BlockType;

    localparam BlockType BLOCK_AIR = 8'h00;

    // Most-negative coordinate marks a reserved position; the cache uses it as its empty tag.
    localparam coord_t TAG_INVALID = {1'b1, {(COORD_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, REQ, WAIT, FILL, DROP} FillState;

    function automatic logic is_reserved(input BlockPos p);
        return (p.x == TAG_INVALID) || (p.y == TAG_INVALID) || (p.z == TAG_INVALID);
    endfunction

endpackage

// File: rtl/l1_fill_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr wins, wrapping.
// Outputs a one-hot grant and its index; both are zero when nothing requests.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            idx = IW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/l1_fill_ctrl.sv
// Miss-service controller for the multi-port L1 block cache: arbitrate, fetch, fill, ack.
// Define L1_FILL_STATS_EN to add the fill_count / stall_cycles statistics outputs.
module l1_fill_ctrl
    import l1_fill_ctrl_pkg::*;
#(
    parameter int PORTS      = 4,
    parameter int CACHE_SIZE = 16
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [PORTS-1:0]              miss_req,
    input  BlockPos [PORTS-1:0]           miss_addr,
    output logic [PORTS-1:0]              miss_ack,
    output logic                          mem_req,
    output BlockPos                       mem_addr,
    input  logic                          mem_ready,
    input  logic                          mem_rvalid,
    input  BlockType                      mem_rdata,
    output logic                          fill_we,
    output logic [$clog2(CACHE_SIZE)-1:0] fill_idx,
    output BlockPos                       fill_tag,
    output BlockType                      fill_data,
    output logic                          busy
`ifdef L1_FILL_STATS_EN
    ,
    output logic [15:0]                   fill_count,
    output logic [15:0]                   stall_cycles
`endif
);

    localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int VW = $clog2(CACHE_SIZE);

    FillState         state_reg, state_next;
    logic [PW-1:0]    grant_reg, grant_next;
    logic [PW-1:0]    rr_ptr_reg, rr_ptr_next;
    BlockPos          addr_reg, addr_next;
    logic [VW-1:0]    victim_reg, victim_next;
    logic [PORTS-1:0] miss_ack_reg, miss_ack_next;
    logic             mem_req_reg, mem_req_next;
    BlockPos          mem_addr_reg, mem_addr_next;
    logic             fill_we_reg, fill_we_next;
    logic [VW-1:0]    fill_idx_reg, fill_idx_next;
    BlockPos          fill_tag_reg, fill_tag_next;
    BlockType         fill_data_reg, fill_data_next;
    logic             busy_reg;

    logic [PORTS-1:0] arb_grant;
    logic [PW-1:0]    arb_idx;
    logic [PORTS-1:0] addr_match;
    logic [PORTS-1:0] grant_onehot;

    rr_arbiter #(.N(PORTS)) u_arb (
        .req       (miss_req),
        .ptr       (rr_ptr_reg),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    // Every other port waiting on the same block is released by the one fill.
    for (genvar gi = 0; gi < PORTS; gi++) begin : g_match
        assign addr_match[gi] = miss_req[gi] && (miss_addr[gi] == addr_reg);
    end

    assign grant_onehot = PORTS'(1) << grant_reg;

    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        rr_ptr_next    = rr_ptr_reg;
        addr_next      = addr_reg;
        victim_next    = victim_reg;
        miss_ack_next  = '0;
        mem_req_next   = 1'b0;
        mem_addr_next  = mem_addr_reg;
        fill_we_next   = 1'b0;
        fill_idx_next  = fill_idx_reg;
        fill_tag_next  = fill_tag_reg;
        fill_data_next = fill_data_reg;
        case (state_reg)
            IDLE: begin
                if (|miss_req) begin
                    grant_next  = arb_idx;
                    addr_next   = miss_addr[arb_idx];
                    rr_ptr_next = (arb_idx == PW'(PORTS - 1)) ? '0 : arb_idx + PW'(1);
                    if (is_reserved(miss_addr[arb_idx])) begin
                        state_next    = DROP;
                        miss_ack_next = arb_grant;
                    end else begin
                        state_next    = REQ;
                        mem_req_next  = 1'b1;
                        mem_addr_next = miss_addr[arb_idx];
                    end
                end
            end
            REQ: begin
                if (mem_ready) state_next = WAIT;
                else           mem_req_next = 1'b1;
            end
            WAIT: begin
                // Outputs are registered, so the fill is staged on the rvalid edge.
                if (mem_rvalid) begin
                    state_next     = FILL;
                    fill_we_next   = 1'b1;
                    fill_idx_next  = victim_reg;
                    fill_tag_next  = addr_reg;
                    fill_data_next = mem_rdata;
                    miss_ack_next  = grant_onehot | addr_match;
                    victim_next    = (victim_reg == VW'(CACHE_SIZE - 1)) ? '0 : victim_reg + VW'(1);
                end
            end
            FILL:    state_next = IDLE;
            DROP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg     <= IDLE;
            grant_reg     <= '0;
            rr_ptr_reg    <= '0;
            addr_reg      <= '0;
            victim_reg    <= '0;
            miss_ack_reg  <= '0;
            mem_req_reg   <= 1'b0;
            mem_addr_reg  <= '0;
            fill_we_reg   <= 1'b0;
            fill_idx_reg  <= '0;
            fill_tag_reg  <= '0;
            fill_data_reg <= BLOCK_AIR;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            rr_ptr_reg    <= rr_ptr_next;
            addr_reg      <= addr_next;
            victim_reg    <= victim_next;
            miss_ack_reg  <= miss_ack_next;
            mem_req_reg   <= mem_req_next;
            mem_addr_reg  <= mem_addr_next;
            fill_we_reg   <= fill_we_next;
            fill_idx_reg  <= fill_idx_next;
            fill_tag_reg  <= fill_tag_next;
            fill_data_reg <= fill_data_next;
            busy_reg      <= (state_next != IDLE);
        end
    end

    assign miss_ack  = miss_ack_reg;
    assign mem_req   = mem_req_reg;
    assign mem_addr  = mem_addr_reg;
    assign fill_we   = fill_we_reg;
    assign fill_idx  = fill_idx_reg;
    assign fill_tag  = fill_tag_reg;
    assign fill_data = fill_data_reg;
    assign busy      = busy_reg;

`ifdef L1_FILL_STATS_EN
    logic [15:0] fill_count_reg;
    logic [15:0] stall_cycles_reg;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            fill_count_reg   <= '0;
            stall_cycles_reg <= '0;
        end else begin
            if (state_reg == FILL && fill_count_reg != 16'hFFFF)
                fill_count_reg <= fill_count_reg + 16'd1;
            if ((state_reg == REQ || state_reg == WAIT) && stall_cycles_reg != 16'hFFFF)
                stall_cycles_reg <= stall_cycles_reg + 16'd1;
        end
    end

    assign fill_count   = fill_count_reg;
    assign stall_cycles = stall_cycles_reg;
`endif

endmodule

// File: tb/tb_l1_fill_ctrl.sv
// Directed bench for l1_fill_ctrl: vector table of single misses plus
// hand-written round-robin/wrap and reset-during-WAIT sequences.
module tb_l1_fill_ctrl;
    import l1_fill_ctrl_pkg::*;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic [3:0]    miss_req;
    BlockPos [3:0] miss_addr;
    logic [3:0]    miss_ack;
    logic          mem_req;
    BlockPos       mem_addr;
    logic          mem_ready;
    logic          mem_rvalid;
    BlockType      mem_rdata;
    logic          fill_we;
    logic [3:0]    fill_idx;
    BlockPos       fill_tag;
    BlockType      fill_data;
    logic          busy;
`ifdef L1_FILL_STATS_EN
    logic [15:0]   fill_count;
    logic [15:0]   stall_cycles;
`endif

    l1_fill_ctrl #(.PORTS(4), .CACHE_SIZE(16)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .miss_req   (miss_req),
        .miss_addr  (miss_addr),
        .miss_ack   (miss_ack),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .fill_we    (fill_we),
        .fill_idx   (fill_idx),
        .fill_tag   (fill_tag),
        .fill_data  (fill_data),
        .busy       (busy)
`ifdef L1_FILL_STATS_EN
        ,
        .fill_count   (fill_count),
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [3:0]    mask;
        BlockPos [3:0] addr;
        int            rdy;
        int            rv;
        BlockType      data;
        logic [3:0]    exp_ack;
        BlockPos       exp_tag;
        bit            reserved;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    int exp_victim = 0;
    vec_t vecs [8];

    function automatic BlockPos pos(input int x, input int y, input int z);
        BlockPos p;
        p.x = coord_t'(x);
        p.y = coord_t'(y);
        p.z = coord_t'(z);
        return p;
    endfunction

    function automatic vec_t mk(input logic [3:0] mask, input BlockPos a0, input BlockPos a1,
                                input BlockPos a2, input BlockPos a3, input int rdy, input int rv,
                                input BlockType data, input logic [3:0] exp_ack,
                                input BlockPos exp_tag, input bit reserved);
        vec_t v;
        v.mask = mask;
        v.addr[0] = a0; v.addr[1] = a1; v.addr[2] = a2; v.addr[3] = a3;
        v.rdy = rdy; v.rv = rv; v.data = data;
        v.exp_ack = exp_ack; v.exp_tag = exp_tag; v.reserved = reserved;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_reset;
        chk("rst busy", busy, 0);
        chk("rst mem_req", mem_req, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst fill_we", fill_we, 0);
        chk("rst fill_idx", fill_idx, 0);
        chk("rst fill_tag", fill_tag, 0);
        chk("rst fill_data", fill_data, BLOCK_AIR);
        chk("rst miss_ack", miss_ack, 0);
    endtask

    // Play the block memory until an ack appears; returns in the ack cycle.
    task automatic serve(input int rdy_dly, input int rv_dly, input BlockType data,
                         output int cycles, output int reads, output bit addr_moved,
                         output bit saw_req, output BlockPos req_addr, output bit timed_out);
        bit hs;
        bit waiting;
        int rd_cnt;
        int rv_cnt;
        cycles = 0; reads = 0; addr_moved = 0; saw_req = 0; req_addr = '0; timed_out = 0;
        waiting = 0; rd_cnt = 0; rv_cnt = 0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = ~data;
        forever begin
            hs = mem_req && mem_ready;
            tick;
            cycles++;
            mem_rvalid = 0;
            mem_rdata = ~data;
            if (hs) begin reads++; waiting = 1; rv_cnt = 0; end
            if (|miss_ack) break;
            if (cycles >= 80) begin timed_out = 1; break; end
            if (mem_req) begin
                if (!saw_req) begin req_addr = mem_addr; saw_req = 1; end
                else if (mem_addr != req_addr) addr_moved = 1;
                mem_ready = (rd_cnt >= rdy_dly);
                rd_cnt++;
            end else begin
                mem_ready = 0;
            end
            if (waiting) begin
                rv_cnt++;
                if (rv_cnt >= rv_dly) begin
                    mem_rvalid = 1;
                    mem_rdata = data;
                    waiting = 0;
                end
            end
        end
        mem_ready = 0;
        mem_rvalid = 0;
    endtask

    task automatic run_vec(input int i, input vec_t v);
        int cycles, reads;
        bit moved, saw_req, to;
        BlockPos req_addr;
        string s;
        miss_addr = v.addr;
        miss_req = v.mask;
        serve(v.rdy, v.rv, v.data, cycles, reads, moved, saw_req, req_addr, to);
        s = $sformatf("v%0d", i);
        $display("vec %0d: mask=%b ack=%b we=%b idx=%0d tag=%h data=%h cycles=%0d reads=%0d",
                 i, v.mask, miss_ack, fill_we, fill_idx, fill_tag, fill_data, cycles, reads);
        chk({s, " timeout"}, to, 0);
        chk({s, " miss_ack"}, miss_ack, v.exp_ack);
        chk({s, " fill_we"}, fill_we, !v.reserved);
        if (v.reserved) begin
            chk({s, " drop latency"}, cycles, 1);
            chk({s, " mem_req seen"}, saw_req, 0);
        end else begin
            chk({s, " fill_idx"}, fill_idx, exp_victim);
            chk({s, " fill_tag"}, fill_tag, v.exp_tag);
            chk({s, " fill_data"}, fill_data, v.data);
            chk({s, " latency"}, cycles, 2 + v.rdy + v.rv);
            chk({s, " reads"}, reads, 1);
            chk({s, " mem_addr"}, req_addr, v.exp_tag);
            chk({s, " mem_addr held"}, moved, 0);
            exp_victim = (exp_victim + 1) % 16;
        end
        miss_req = miss_req & ~miss_ack;
        tick;
        chk({s, " busy after"}, busy, 0);
        chk({s, " ack pulse"}, miss_ack, 0);
        chk({s, " we pulse"}, fill_we, 0);
    endtask

    initial begin
        int cycles, reads, n;
        bit moved, saw_req, to;
        BlockPos req_addr;
        BlockPos z0;

        z0 = pos(0, 0, 0);
        vecs[0] = mk(4'b0100, z0, z0, pos(1, 2, 3), z0, 0, 1, 8'h05, 4'b0100, pos(1, 2, 3), 0);
        vecs[1] = mk(4'b1001, pos(4, 4, 4), z0, z0, pos(4, 4, 4), 0, 1, 8'h11, 4'b1001, pos(4, 4, 4), 0);
        vecs[2] = mk(4'b0010, z0, pos(-8, 0, 0), z0, z0, 0, 1, 8'h00, 4'b0010, pos(-8, 0, 0), 1);
        vecs[3] = mk(4'b0001, pos(0, -8, 5), z0, z0, z0, 0, 1, 8'h00, 4'b0001, pos(0, -8, 5), 1);
        vecs[4] = mk(4'b0100, z0, z0, pos(7, 7, -7), z0, 5, 3, 8'hA5, 4'b0100, pos(7, 7, -7), 0);
        vecs[5] = mk(4'b1000, z0, z0, z0, pos(-7, -1, 0), 2, 1, 8'h3C, 4'b1000, pos(-7, -1, 0), 0);
        vecs[6] = mk(4'b0010, z0, pos(3, 0, -8), z0, z0, 0, 1, 8'h00, 4'b0010, pos(3, 0, -8), 1);
        vecs[7] = mk(4'b0110, z0, pos(6, 5, 4), pos(6, 5, 4), z0, 1, 2, 8'hFF, 4'b0110, pos(6, 5, 4), 0);

        rst_in = 1; miss_req = 0; miss_addr = '0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
        tick; tick; tick;
        check_reset;
        rst_in = 0;
        tick;

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Round robin with all ports missing continuously, then victim wrap.
        rst_in = 1;
        tick;
        check_reset;
        rst_in = 0;
        tick;
        for (int p = 0; p < 4; p++) miss_addr[p] = pos(p, 1, 2);
        miss_req = 4'hF;
        for (int k = 0; k < 17; k++) begin
            serve(0, 1, BlockType'(8'h40 + k), cycles, reads, moved, saw_req, req_addr, to);
            $display("rr fill %0d: ack=%b idx=%0d tag=%h data=%h", k, miss_ack, fill_idx, fill_tag, fill_data);
            chk($sformatf("rr%0d timeout", k), to, 0);
            chk($sformatf("rr%0d grant", k), miss_ack, 4'b0001 << (k % 4));
            chk($sformatf("rr%0d fill_idx", k), fill_idx, k % 16);
            chk($sformatf("rr%0d fill_tag", k), fill_tag, pos(k % 4, 1, 2));
            chk($sformatf("rr%0d fill_data", k), fill_data, 8'h40 + k);
        end
        miss_req = 0;
        tick;
        tick;

        // Reset while waiting for read data.
        miss_addr[0] = pos(2, 2, 2);
        miss_req = 4'b0001;
        mem_ready = 1;
        n = 0;
        while (!mem_req && n < 20) begin tick; n++; end
        chk("rstwait reach REQ", mem_req, 1);
        tick;
        mem_ready = 0;
        $display("rstwait: in WAIT busy=%b mem_req=%b", busy, mem_req);
        chk("rstwait busy in WAIT", busy, 1);
        chk("rstwait req dropped", mem_req, 0);
        rst_in = 1; miss_req = 0;
        tick;
        $display("rstwait: after reset busy=%b mem_req=%b we=%b ack=%b", busy, mem_req, fill_we, miss_ack);
        chk("rstwait busy", busy, 0);
        chk("rstwait mem_req", mem_req, 0);
        chk("rstwait fill_we", fill_we, 0);
        chk("rstwait miss_ack", miss_ack, 0);
        chk("rstwait fill_idx", fill_idx, 0);
        rst_in = 0;
        mem_rvalid = 1; mem_rdata = 8'h77;
        tick;
        mem_rvalid = 0;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("idle rvalid ignored we c%0d", c), fill_we, 0);
            chk($sformatf("idle rvalid ignored ack c%0d", c), miss_ack, 0);
            tick;
        end
        exp_victim = 0;
        run_vec(8, mk(4'b1000, z0, z0, z0, pos(5, 5, 5), 0, 1, 8'h5A, 4'b1000, pos(5, 5, 5), 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 200000", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/l1_fill_ctrl.md
Name: l1_fill_ctrl

Overview:
- Miss-service controller for the N-port single-cycle L1 block cache.
- Collects per-port misses and arbitrates them round-robin.
- Fetches each granted block from the chunk block memory over a valid/ready request and rvalid response interface.
- Writes the block into the cache's fill port at a cyclic victim slot, then acks every waiting port whose address was filled.

Parameters:
- PORTS, 4, number of cache lookup ports served.
- CACHE_SIZE, 16, cache entries; victim pointer range 0..CACHE_SIZE-1.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  reset.
- miss_req  in  PORTS  port i has an outstanding miss; held until miss_ack[i].
- miss_addr  in  PORTS x $bits(BlockPos)  missed position per port; stable while miss_req high.
- miss_ack  out  PORTS  1-cycle pulse: block written, retry lookup.
- mem_req  out  1  memory read request valid.
- mem_addr  out  $bits(BlockPos)  read position.
- mem_ready  in  1  request accepted when mem_req && mem_ready.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  $bits(BlockType)  read data.
- fill_we  out  1  cache write strobe.
- fill_idx  out  $clog2(CACHE_SIZE)  victim entry.
- fill_tag  out  $bits(BlockPos)  tag written.
- fill_data  out  $bits(BlockType)  block written.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Single clock clk_in; reset rst_in synchronous, active-high.
- Reset outputs: miss_ack=0, mem_req=0, mem_addr=0, fill_we=0, fill_idx=0, fill_tag=0, fill_data=BLOCK_AIR, busy=0.
- Reset internal state: victim pointer=0, round-robin pointer=0, state=IDLE.
- All outputs are registered.
- FSM IDLE:
  - If any miss_req is set, grant the first requesting port at or after rr_ptr (wrapping).
  - Latch grant index and its address; set rr_ptr=grant+1 mod PORTS.
  - If the address is valid, go to REQ. If it is reserved (see below), go to DROP.
- Reserved address: any coordinate equals TAG_INVALID (most-negative value of its coordinate width).
- DROP: pulse miss_ack[grant] for one cycle; no memory access, no cache write; then IDLE.
- REQ: mem_req=1, mem_addr=latched address. Hold until mem_ready, then go to WAIT and drop mem_req the next cycle.
- WAIT: wait for mem_rvalid; latch mem_rdata; go to FILL. mem_rvalid outside WAIT is ignored.
- FILL (one cycle):
  - fill_we=1, fill_idx=victim pointer, fill_tag=latched address, fill_data=latched data.
  - miss_ack[j]=1 for the granted port and for every port j with miss_req[j] && miss_addr[j]==latched address (duplicate merge).
  - Victim pointer increments, wrapping CACHE_SIZE-1 -> 0.
  - Next state IDLE.
- Minimum latency, with mem_ready=1 and rvalid one cycle after accept:
  - miss_req sampled cycle 0, REQ cycle 1, WAIT cycle 2, FILL/ack cycle 3.
  - Back-to-back: the next grant is evaluated in the IDLE cycle following FILL.
- Requester drops miss_req before ack: the fill still completes and the ack pulse is still issued (harmlessly).
- Granted port reasserts the same address after ack: it is a new miss and is re-serviced; the cache normally hits first.
- Only one read is ever in flight.
- Block memory shares rst_in, so no stale rvalid can arrive after reset.
- Reset mid-operation: return to IDLE immediately; mem_req drops the same cycle; the partial fill is discarded.
- Victim pointer is never skipped: entries are overwritten strictly cyclically, including the entry just filled by the duplicate merge.

Optional Feature:
- Macro: L1_FILL_STATS_EN.
- Defined:
  - Adds outputs fill_count (16 bits) and stall_cycles (16 bits), both saturating at 0xFFFF and cleared by rst_in.
  - fill_count increments on each FILL.
  - stall_cycles increments on each cycle in REQ or WAIT.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package types.sv: BlockPos, BlockType, BLOCK_AIR, `CHUNK_WIDTH.
- Add TAG_INVALID to the package; the cache uses the same constant.
- Add state enum FillState {IDLE, REQ, WAIT, FILL, DROP} to the package.
- One sub-module: rr_arbiter #(N) — request vector plus pointer in, one-hot grant and index out; purely combinational, reused later for chunk-loader sharing.

Test Plan:
- Single miss: port 2 addr (1,2,3), mem_ready=1, rvalid one cycle later with data 0x05 -> cycle 3: fill_we=1, fill_idx=0, fill_tag=(1,2,3), fill_data=0x05, miss_ack=4'b0100.
- Round robin: all four ports miss distinct addresses continuously -> grant order 0,1,2,3,0 across fills; fill_idx 0,1,2,3,4.
- Duplicate merge: ports 0 and 3 miss (4,4,4) in the same cycle -> one memory read; FILL cycle miss_ack=4'b1001.
- Reserved address: port 1 addr (-8,0,0) with CHUNK_WIDTH=16 -> DROP; miss_ack=4'b0010; mem_req never asserted; fill_we stays 0.
- Backpressure and wrap: mem_ready low 5 cycles, rvalid delayed 3 -> mem_req and mem_addr held stable; 17 fills with CACHE_SIZE=16 -> 17th fill_idx=0.
- Reset in WAIT: assert rst_in -> next cycle busy=0, mem_req=0, no fill_we, no miss_ack; fill_idx restarts at 0.
